audio_play_ctrl: RTL and testbench
==================================

# audio_play_ctrl

Playback sequencer for the audio datapath. Accepts start/stop from the Nios II (Avalon-MM slave registers) or from the front-panel play/stop buttons, fetches 16-bit samples from sample memory over an Avalon-MM read master, and feeds them to the codec DAC stream with a valid/ready handshake. It raises a maskable interrupt when a non-looping playback finishes.

## Interface
- ADDR_W, 20: sample memory word-address width.
- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous, active-low.
- address  in  3  slave register index.
- chipselect, write_n  in  1  slave strobes; write when chipselect && !write_n.
- writedata  in  32  slave write data.
- readdata  out  32  slave read data, registered.
- irq  out  1  level interrupt = done_flag & irq_mask.
- play_btn, stop_btn  in  1  asynchronous button levels, active-high.
- mem_address  out  ADDR_W  sample word address.
- mem_read  out  1  read request; held until !mem_waitrequest.
- mem_waitrequest  in  1  slave stall.
- mem_readdata  in  16  sample word.
- mem_readdatavalid  in  1  read data strobe.
- sample_data  out  16  signed sample to DAC stream.
- sample_valid  out  1  sample_data valid.
- sample_ready  in  1  DAC stream accepts.

## Operation
- Registers: 0 CTRL (W: bit0 START pulse, bit1 STOP pulse, bit2 LOOP stored; R: bit2 LOOP); 1 START_ADDR; 2 END_ADDR (inclusive); 3 STATUS (bit0 BUSY RO, bit1 DONE sticky, write 1 clears); 4 IRQ_MASK bit0; 5 CUR_ADDR RO; 6 VOLUME (see Configuration). Unused bits read 0; offset 7 reads 0.
- Buttons: 2-flop synchronizer, rising-edge detect (d1 & ~d2); play edge = START, stop edge = STOP.
- FSM: IDLE -> FETCH (mem_read=1, mem_address=cur) -> WAIT (on !mem_waitrequest) -> PUSH (on mem_readdatavalid; latch sample) -> back to FETCH after sample_valid&&sample_ready.
- After the PUSH handshake: cur==END_ADDR and LOOP=1 -> cur=START_ADDR, FETCH; cur==END_ADDR and LOOP=0 -> IDLE, DONE=1; otherwise cur+1, FETCH.
- START in IDLE: cur=START_ADDR; if START_ADDR>END_ADDR go nowhere, set DONE=1. START while BUSY: ignored.
- STOP: latched as stop_pend; in FETCH before acceptance -> drop mem_read, go IDLE; in WAIT/PUSH -> finish current sample handshake, then IDLE. DONE not set by STOP. stop_pend cleared on entering IDLE.
- START and STOP same cycle (any source): STOP wins, START discarded.
- BUSY = state != IDLE. Register writes to START/END/LOOP while BUSY take effect at next compare.

## Timing
- Reset values: readdata 0, irq 0, mem_read 0, mem_address 0, sample_valid 0, sample_data 0; all registers 0; state IDLE.
- START write in cycle N -> BUSY and mem_read high in N+1.
- Button edge: mem_read high 3 cycles after button rises (2 sync + 1).
- mem_readdatavalid in cycle M -> sample_valid high M+1; held with stable sample_data until ready.
- Zero-wait memory and always-ready sink: one sample per 3 cycles.
- readdata reflects register state one cycle after address presented, every cycle (no read strobe).
- Reset mid-playback: immediate IDLE; outstanding read response ignored.

## Configuration
- AUDIO_PLAY_VOLUME_EN defined: VOLUME register bits[2:0] = attenuation; sample_data = mem sample arithmetically shifted right by VOLUME, applied at latch time.
- Not defined: offset 6 reads 0, writes ignored; sample_data = mem_readdata unchanged.

## Structure
- audio_play_pkg: register offset constants, CTRL/STATUS bit positions, FSM state enum (IDLE, FETCH, WAIT, PUSH).
- Sub-module btn_edge_sync (2-flop sync + rising edge), instantiated for play_btn and stop_btn.

## Test plan
- START=0x10, END=0x12, LOOP=0, memory 0x1000/0x2000/0x3000 -> samples 0x1000,0x2000,0x3000 out, then BUSY=0, DONE=1; irq=1 only if IRQ_MASK=1.
- LOOP=1, START=5, END=6 -> addresses 5,6,5,6...; STOP write -> current sample completes, BUSY=0, DONE=0.
- sample_ready low 10 cycles in PUSH -> sample_data stable, no new mem_read issued.
- mem_waitrequest high 4 cycles -> mem_read/mem_address held; STOP during stall -> mem_read drops, IDLE next cycle.
- Play and stop buttons rise same cycle -> no playback; START with START_ADDR=9 > END_ADDR=3 -> DONE=1 immediately, no mem_read.
- With AUDIO_PLAY_VOLUME_EN, VOLUME=2, sample 0x8000 -> 0xE000; reset_n low mid-PUSH -> all outputs 0 next cycle.

Source files
------------

// File: rtl/audio_play_pkg.sv
// audio_play_pkg: shared constants for the playback sequencer.
// Register offsets, CTRL/STATUS bit positions, the FSM state type and the
// volume attenuation helper used when AUDIO_PLAY_VOLUME_EN is defined.
package audio_play_pkg;

   localparam logic [2:0] REG_CTRL       = 3'd0;
   localparam logic [2:0] REG_START_ADDR = 3'd1;
   localparam logic [2:0] REG_END_ADDR   = 3'd2;
   localparam logic [2:0] REG_STATUS     = 3'd3;
   localparam logic [2:0] REG_IRQ_MASK   = 3'd4;
   localparam logic [2:0] REG_CUR_ADDR   = 3'd5;
   localparam logic [2:0] REG_VOLUME     = 3'd6;

   localparam int CTRL_START_BIT  = 0;
   localparam int CTRL_STOP_BIT   = 1;
   localparam int CTRL_LOOP_BIT   = 2;

   localparam int STATUS_BUSY_BIT = 0;
   localparam int STATUS_DONE_BIT = 1;

   localparam int VOLUME_W = 3;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      WAIT,
      PUSH
   } play_state_t;

   // Arithmetic right shift of a signed 16-bit sample by the volume setting.
   function automatic logic [15:0] attenuate(input logic [15:0] sample,
                                             input logic [VOLUME_W-1:0] shift);
      logic signed [15:0] s;
      s = $signed(sample);
      return s >>> shift;
   endfunction

endpackage

// File: rtl/audio_play_btn_edge_sync.sv
// btn_edge_sync: brings an asynchronous button level into the clk domain
// through two flops and emits a one-cycle pulse on each rising edge.
module btn_edge_sync (
   input  logic clk,
   input  logic reset_n,
   input  logic btn,
   output logic rise
);

   logic sync_q1;
   logic sync_q2;
   logic hist_q;

   // Two-flop synchronizer followed by a history flop for edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
         hist_q  <= 1'b0;
      end else begin
         sync_q1 <= btn;
         sync_q2 <= sync_q1;
         hist_q  <= sync_q2;
      end
   end

   assign rise = sync_q2 & ~hist_q;

endmodule

// File: rtl/audio_play_ctrl.sv
// audio_play_ctrl: playback sequencer. Nios II registers or front-panel
// buttons start/stop playback; samples are read from sample memory over an
// Avalon-MM read master and handed to the DAC stream with valid/ready.
// Optional feature macro: AUDIO_PLAY_VOLUME_EN adds the VOLUME register and
// applies an arithmetic right shift to each sample as it is latched.
module audio_play_ctrl
   import audio_play_pkg::*;
#(
   parameter int ADDR_W = 20
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [2:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic              irq,
   input  logic              play_btn,
   input  logic              stop_btn,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_read,
   input  logic              mem_waitrequest,
   input  logic [15:0]       mem_readdata,
   input  logic              mem_readdatavalid,
   output logic [15:0]       sample_data,
   output logic              sample_valid,
   input  logic              sample_ready
);

   play_state_t       state_q, state_d;
   logic [ADDR_W-1:0] cur_q, cur_d;
   logic [ADDR_W-1:0] start_addr, end_addr;
   logic              loop_en, irq_mask, done_flag, done_set;
   logic              stop_pend_q, stop_pend_d;
   logic [15:0]       sample_q, sample_d, latched_sample;
   logic              play_rise, stop_rise;
   logic              reg_write, ctrl_write;
   logic              start_req, stop_req, go_req, busy;
   logic [31:0]       read_mux;
   logic              unused_wdata;
`ifdef AUDIO_PLAY_VOLUME_EN
   logic [VOLUME_W-1:0] volume;
`endif

   btn_edge_sync u_play_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .btn     (play_btn),
      .rise    (play_rise)
   );

   btn_edge_sync u_stop_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .btn     (stop_btn),
      .rise    (stop_rise)
   );

   assign reg_write  = chipselect && !write_n;
   assign ctrl_write = reg_write && (address == REG_CTRL);
   assign start_req  = (ctrl_write && writedata[CTRL_START_BIT]) || play_rise;
   assign stop_req   = (ctrl_write && writedata[CTRL_STOP_BIT]) || stop_rise;
   // A simultaneous stop always cancels a start, whatever the sources.
   assign go_req     = start_req && !stop_req;
   assign busy       = (state_q != IDLE);
   assign unused_wdata = &{1'b0, writedata};

`ifdef AUDIO_PLAY_VOLUME_EN
   assign latched_sample = attenuate(mem_readdata, volume);
`else
   assign latched_sample = mem_readdata;
`endif

   // Software-visible configuration registers and the sticky DONE flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         loop_en    <= 1'b0;
         start_addr <= '0;
         end_addr   <= '0;
         irq_mask   <= 1'b0;
         done_flag  <= 1'b0;
`ifdef AUDIO_PLAY_VOLUME_EN
         volume     <= '0;
`endif
      end else begin
         if (reg_write) begin
            case (address)
               REG_CTRL:       loop_en    <= writedata[CTRL_LOOP_BIT];
               REG_START_ADDR: start_addr <= writedata[ADDR_W-1:0];
               REG_END_ADDR:   end_addr   <= writedata[ADDR_W-1:0];
               REG_IRQ_MASK:   irq_mask   <= writedata[0];
`ifdef AUDIO_PLAY_VOLUME_EN
               REG_VOLUME:     volume     <= writedata[VOLUME_W-1:0];
`endif
               default: ;
            endcase
         end
         if (done_set) begin
            done_flag <= 1'b1;
         end else if (reg_write && (address == REG_STATUS) && writedata[STATUS_DONE_BIT]) begin
            done_flag <= 1'b0;
         end
      end
   end

   // Read mux for the register selected by the current address.
   always_comb begin
      read_mux = '0;
      case (address)
         REG_CTRL:       read_mux[CTRL_LOOP_BIT] = loop_en;
         REG_START_ADDR: read_mux[ADDR_W-1:0]    = start_addr;
         REG_END_ADDR:   read_mux[ADDR_W-1:0]    = end_addr;
         REG_STATUS: begin
            read_mux[STATUS_BUSY_BIT] = busy;
            read_mux[STATUS_DONE_BIT] = done_flag;
         end
         REG_IRQ_MASK:   read_mux[0]             = irq_mask;
         REG_CUR_ADDR:   read_mux[ADDR_W-1:0]    = cur_q;
`ifdef AUDIO_PLAY_VOLUME_EN
         REG_VOLUME:     read_mux[VOLUME_W-1:0]  = volume;
`endif
         default: ;
      endcase
   end

   // Registered read data, refreshed every cycle without a read strobe.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
      end else begin
         readdata <= read_mux;
      end
   end

   // Sequencer state, current address, pending stop and the held sample.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cur_q       <= '0;
         stop_pend_q <= 1'b0;
         sample_q    <= '0;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         stop_pend_q <= stop_pend_d;
         sample_q    <= sample_d;
      end
   end

   // Next-state logic: fetch a word, wait for its data, push it downstream,
   // then advance, wrap or finish; a stop only cuts in before a read is accepted.
   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      sample_d    = sample_q;
      done_set    = 1'b0;
      stop_pend_d = stop_pend_q || (stop_req && (state_q != IDLE));
      case (state_q)
         IDLE: begin
            if (go_req) begin
               cur_d = start_addr;
               if (start_addr > end_addr) begin
                  done_set = 1'b1;
               end else begin
                  state_d = FETCH;
               end
            end
         end
         FETCH: begin
            if (!mem_waitrequest) begin
               state_d = WAIT;
            end else if (stop_pend_d) begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (mem_readdatavalid) begin
               sample_d = latched_sample;
               state_d  = PUSH;
            end
         end
         PUSH: begin
            if (sample_ready) begin
               if (stop_pend_d) begin
                  state_d = IDLE;
               end else if (cur_q == end_addr) begin
                  if (loop_en) begin
                     cur_d   = start_addr;
                     state_d = FETCH;
                  end else begin
                     done_set = 1'b1;
                     state_d  = IDLE;
                  end
               end else begin
                  cur_d   = cur_q + 1'b1;
                  state_d = FETCH;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (state_d == IDLE) begin
         stop_pend_d = 1'b0;
      end
   end

   assign mem_read     = (state_q == FETCH);
   assign mem_address  = cur_q;
   assign sample_valid = (state_q == PUSH);
   assign sample_data  = sample_q;
   assign irq          = done_flag & irq_mask;

endmodule

// File: tb/tb_audio_play_ctrl.sv
// tb_audio_play_ctrl: scoreboard bench for audio_play_ctrl. Playback requests
// push the expected read addresses and samples into queues; independent
// monitors pop and compare on every accepted read and every sample handshake.
module tb_audio_play_ctrl;
   import audio_play_pkg::*;

   localparam int ADDR_W = 20;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [2:0]        address;
   logic              chipselect;
   logic              write_n;
   logic [31:0]       writedata;
   logic [31:0]       readdata;
   logic              irq;
   logic              play_btn;
   logic              stop_btn;
   logic [ADDR_W-1:0] mem_address;
   logic              mem_read;
   logic              mem_waitrequest;
   logic [15:0]       mem_readdata;
   logic              mem_readdatavalid;
   logic [15:0]       sample_data;
   logic              sample_valid;
   logic              sample_ready;

   int checks = 0;
   int errors = 0;
   int stallMode = 0;
   int sinkMode = 0;
   int volShift = 0;

   logic [15:0]       memImg [0:255];
   logic [ADDR_W-1:0] addrQ [$];
   logic [15:0]       dataQ [$];

   always #5 clk = ~clk;

   audio_play_ctrl #(.ADDR_W(ADDR_W)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .address           (address),
      .chipselect        (chipselect),
      .write_n           (write_n),
      .writedata         (writedata),
      .readdata          (readdata),
      .irq               (irq),
      .play_btn          (play_btn),
      .stop_btn          (stop_btn),
      .mem_address       (mem_address),
      .mem_read          (mem_read),
      .mem_waitrequest   (mem_waitrequest),
      .mem_readdata      (mem_readdata),
      .mem_readdatavalid (mem_readdatavalid),
      .sample_data       (sample_data),
      .sample_valid      (sample_valid),
      .sample_ready      (sample_ready)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Reference for the volume shift: floor division by a power of two.
   function automatic logic [15:0] expectedSample(input logic [15:0] raw);
      int v, d, q;
      v = int'($signed(raw));
      d = 1 << volShift;
      q = v / d;
      if (((v % d) != 0) && (v < 0)) q = q - 1;
      return q[15:0];
   endfunction

   function automatic void expectPlayback(input int sa, input int ea, input bit loop);
      int reps;
      reps = loop ? 40 : 1;
      if (sa <= ea) begin
         for (int r = 0; r < reps; r++) begin
            for (int a = sa; a <= ea; a++) begin
               addrQ.push_back(ADDR_W'(a));
               dataQ.push_back(expectedSample(memImg[a]));
            end
         end
      end
   endfunction

   task automatic regWrite(input logic [2:0] a, input logic [31:0] d);
      address = a;
      writedata = d;
      chipselect = 1'b1;
      write_n = 1'b0;
      @(posedge clk); #1;
      chipselect = 1'b0;
      write_n = 1'b1;
   endtask

   task automatic regRead(input logic [2:0] a, output logic [31:0] d);
      address = a;
      chipselect = 1'b1;
      write_n = 1'b1;
      @(posedge clk); #1;
      d = readdata;
      chipselect = 1'b0;
   endtask

   task automatic applyStimulus(input int sa, input int ea, input bit loop, input bit viaButton);
      regWrite(REG_START_ADDR, 32'(sa));
      regWrite(REG_END_ADDR, 32'(ea));
      expectPlayback(sa, ea, loop);
      if (!viaButton) regWrite(REG_CTRL, {29'd0, loop, 2'b01});
   endtask

   task automatic waitIdle(input int budget);
      logic [31:0] s;
      int n;
      n = 0;
      do begin
         regRead(REG_STATUS, s);
         n++;
      end while (s[STATUS_BUSY_BIT] && (n < budget));
      checkOutput("busy clears", {31'd0, s[STATUS_BUSY_BIT]}, 32'd0);
   endtask

   task automatic checkDrained(input string name);
      checkOutput({name, " samples left"}, 32'(dataQ.size()), 32'd0);
      checkOutput({name, " reads left"}, 32'(addrQ.size()), 32'd0);
   endtask

   task automatic flushExpect();
      addrQ.delete();
      dataQ.delete();
   endtask

   task automatic waitSampleValid();
      int n;
      n = 0;
      while (!sample_valid && (n < 100)) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("sample_valid arrives", {31'd0, sample_valid}, 32'd1);
   endtask

   // Memory slave and sink model; also checks every accepted read address.
   initial begin : memModel
      logic acc;
      logic [7:0] a;
      mem_waitrequest = 1'b0;
      mem_readdatavalid = 1'b0;
      mem_readdata = '0;
      sample_ready = 1'b1;
      forever begin
         @(negedge clk);
         acc = mem_read && !mem_waitrequest;
         a = mem_address[7:0];
         if (acc) begin
            if (addrQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected read: got address 0x%0h, expected no read", mem_address);
            end else begin
               checkOutput("read address", 32'(mem_address), 32'(addrQ.pop_front()));
            end
         end
         @(posedge clk); #1;
         mem_readdatavalid = acc;
         mem_readdata = acc ? memImg[a] : 16'($urandom);
         case (stallMode)
            0:       mem_waitrequest = 1'b0;
            1:       mem_waitrequest = ($urandom_range(0, 3) == 0);
            default: mem_waitrequest = 1'b1;
         endcase
         case (sinkMode)
            0:       sample_ready = 1'b1;
            1:       sample_ready = 1'($urandom_range(0, 1));
            default: sample_ready = 1'b0;
         endcase
      end
   end

   // Stream monitor: pops the scoreboard on each handshake, checks hold behaviour.
   initial begin : sampleMonitor
      logic prevHold;
      logic [15:0] prevData;
      prevHold = 1'b0;
      prevData = '0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            prevHold = 1'b0;
         end else if (sample_valid) begin
            if (prevHold) checkOutput("sample held stable", 32'(sample_data), 32'(prevData));
            if (sample_ready) begin
               if (dataQ.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected sample: got 0x%0h, expected none", sample_data);
               end else begin
                  checkOutput("sample data", 32'(sample_data), 32'(dataQ.pop_front()));
               end
               prevHold = 1'b0;
            end else begin
               prevHold = 1'b1;
               prevData = sample_data;
            end
         end else begin
            if (prevHold) checkOutput("valid held until ready", {31'd0, sample_valid}, 32'd1);
            prevHold = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "[TB] timeout");
   end

   initial begin : mainSeq
      logic [31:0] rd;
      int sa, ea, mask;
      reset_n = 1'b0;
      address = '0;
      chipselect = 1'b0;
      write_n = 1'b1;
      writedata = '0;
      play_btn = 1'b0;
      stop_btn = 1'b0;
      for (int i = 0; i < 256; i++) memImg[i] = 16'($urandom);
      memImg[8'h10] = 16'h1000;
      memImg[8'h11] = 16'h2000;
      memImg[8'h12] = 16'h3000;
      memImg[8'h50] = 16'h8000;
      memImg[8'h51] = 16'h7FFF;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset readdata", readdata, 32'd0);
      checkOutput("reset irq", {31'd0, irq}, 32'd0);
      checkOutput("reset mem_read", {31'd0, mem_read}, 32'd0);
      checkOutput("reset mem_address", 32'(mem_address), 32'd0);
      checkOutput("reset sample_valid", {31'd0, sample_valid}, 32'd0);
      checkOutput("reset sample_data", 32'(sample_data), 32'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;
      regRead(REG_STATUS, rd);
      checkOutput("status after reset", rd, 32'd0);

      $display("[TB] basic three-sample playback");
      regWrite(REG_IRQ_MASK, 32'd0);
      applyStimulus(16'h10, 16'h12, 1'b0, 1'b0);
      checkOutput("mem_read after START", {31'd0, mem_read}, 32'd1);
      checkOutput("first address", 32'(mem_address), 32'h10);
      waitIdle(200);
      checkDrained("basic");
      regRead(REG_STATUS, rd);
      checkOutput("status done", rd, 32'd2);
      checkOutput("irq masked", {31'd0, irq}, 32'd0);
      regWrite(REG_IRQ_MASK, 32'd1);
      checkOutput("irq unmasked", {31'd0, irq}, 32'd1);
      regRead(REG_CUR_ADDR, rd);
      checkOutput("cur addr at end", rd, 32'h12);
      regWrite(REG_STATUS, 32'd2);
      checkOutput("irq after clear", {31'd0, irq}, 32'd0);

      $display("[TB] looping playback stopped by register");
      applyStimulus(5, 6, 1'b1, 1'b0);
      regRead(REG_CTRL, rd);
      checkOutput("ctrl loop readback", rd, 32'd4);
      repeat (25) @(posedge clk);
      #1;
      regWrite(REG_CTRL, 32'd6);
      waitIdle(200);
      checkOutput("loop samples delivered", {31'd0, (80 - dataQ.size()) >= 4}, 32'd1);
      regRead(REG_STATUS, rd);
      checkOutput("stop leaves done clear", rd, 32'd0);
      flushExpect();
      regWrite(REG_CTRL, 32'd0);

      $display("[TB] sink backpressure");
      sinkMode = 2;
      @(posedge clk); #1;
      applyStimulus(16'h20, 16'h22, 1'b0, 1'b0);
      waitSampleValid();
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         checkOutput("no fetch while pushing", {31'd0, mem_read}, 32'd0);
      end
      sinkMode = 0;
      waitIdle(200);
      checkDrained("backpressure");
      regWrite(REG_STATUS, 32'd2);

      $display("[TB] memory stall then stop");
      stallMode = 2;
      repeat (2) @(posedge clk);
      #1;
      applyStimulus(16'h30, 16'h33, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         checkOutput("mem_read held in stall", {31'd0, mem_read}, 32'd1);
         checkOutput("address held in stall", 32'(mem_address), 32'h30);
         @(posedge clk); #1;
      end
      regWrite(REG_CTRL, 32'd2);
      checkOutput("mem_read drops on stop", {31'd0, mem_read}, 32'd0);
      waitIdle(20);
      regRead(REG_STATUS, rd);
      checkOutput("stall stop done clear", rd, 32'd0);
      stallMode = 0;
      flushExpect();

      $display("[TB] simultaneous buttons");
      regWrite(REG_START_ADDR, 32'h40);
      regWrite(REG_END_ADDR, 32'h41);
      play_btn = 1'b1;
      stop_btn = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         checkOutput("no read on play+stop", {31'd0, mem_read}, 32'd0);
      end
      play_btn = 1'b0;
      stop_btn = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      $display("[TB] play button latency");
      applyStimulus(16'h40, 16'h41, 1'b0, 1'b1);
      play_btn = 1'b1;
      @(posedge clk); #1;
      checkOutput("btn cycle1 mem_read", {31'd0, mem_read}, 32'd0);
      @(posedge clk); #1;
      checkOutput("btn cycle2 mem_read", {31'd0, mem_read}, 32'd0);
      @(posedge clk); #1;
      checkOutput("btn cycle3 mem_read", {31'd0, mem_read}, 32'd1);
      play_btn = 1'b0;
      waitIdle(200);
      checkDrained("button");
      regWrite(REG_STATUS, 32'd2);

      $display("[TB] empty range");
      regWrite(REG_START_ADDR, 32'd9);
      regWrite(REG_END_ADDR, 32'd3);
      regWrite(REG_CTRL, 32'd1);
      checkOutput("no read empty range", {31'd0, mem_read}, 32'd0);
      regRead(REG_STATUS, rd);
      checkOutput("empty range done", rd, 32'd2);
      regRead(REG_CUR_ADDR, rd);
      checkOutput("empty range cur", rd, 32'd9);
      regWrite(REG_STATUS, 32'd2);

      $display("[TB] volume");
      regWrite(REG_VOLUME, 32'd2);
      regRead(REG_VOLUME, rd);
`ifdef AUDIO_PLAY_VOLUME_EN
      checkOutput("volume readback", rd, 32'd2);
      volShift = 2;
`else
      checkOutput("volume readback", rd, 32'd0);
      volShift = 0;
`endif
      applyStimulus(16'h50, 16'h51, 1'b0, 1'b0);
      waitIdle(200);
      checkDrained("volume");
      regWrite(REG_STATUS, 32'd2);

      $display("[TB] randomized playbacks");
      for (int it = 0; it < 8; it++) begin
         sa = $urandom_range(0, 200);
         ea = sa + $urandom_range(0, 5);
         mask = $urandom_range(0, 1);
         regWrite(REG_IRQ_MASK, 32'(mask));
         stallMode = 1;
         sinkMode = 1;
         applyStimulus(sa, ea, 1'b0, 1'b0);
         waitIdle(2000);
         checkDrained("random");
         regRead(REG_STATUS, rd);
         checkOutput("random done", rd, 32'd2);
         checkOutput("random irq", {31'd0, irq}, 32'(mask));
         regRead(REG_CUR_ADDR, rd);
         checkOutput("random cur addr", rd, 32'(ea));
         regWrite(REG_STATUS, 32'd2);
         stallMode = 0;
         sinkMode = 0;
         repeat (2) @(posedge clk);
         #1;
      end

      $display("[TB] reset during push");
      sinkMode = 2;
      @(posedge clk); #1;
      applyStimulus(16'h60, 16'h62, 1'b0, 1'b0);
      waitSampleValid();
      reset_n = 1'b0;
      @(posedge clk); #1;
      checkOutput("rst mem_read", {31'd0, mem_read}, 32'd0);
      checkOutput("rst mem_address", 32'(mem_address), 32'd0);
      checkOutput("rst sample_valid", {31'd0, sample_valid}, 32'd0);
      checkOutput("rst sample_data", 32'(sample_data), 32'd0);
      checkOutput("rst readdata", readdata, 32'd0);
      checkOutput("rst irq", {31'd0, irq}, 32'd0);
      reset_n = 1'b1;
      sinkMode = 0;
      volShift = 0;
      flushExpect();
      @(posedge clk); #1;
      regRead(REG_STATUS, rd);
      checkOutput("status after mid reset", rd, 32'd0);
      regRead(REG_START_ADDR, rd);
      checkOutput("start addr after reset", rd, 32'd0);
      repeat (5) @(posedge clk);
      #1;

      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
